// File: rtl/nanov_periph_ctrl_pkg.sv
// nanoV peripheral controller: shared types, address map defaults
// and the status register layout.
package nanov_periph_pkg;

    localparam logic [31:0] DEF_ADDR_GPIO        = 32'h1000_0000;
    localparam logic [31:0] DEF_ADDR_UART        = 32'h1000_0010;
    localparam logic [31:0] DEF_ADDR_UART_STATUS = 32'h1000_0014;

    typedef enum logic [1:0] {
        SEL_NONE   = 2'd0,
        SEL_GPIO   = 2'd1,
        SEL_UART   = 2'd2,
        SEL_STATUS = 2'd3
    } sel_e;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DRAIN = 2'd2
    } tx_st_e;

    localparam int STAT_PENDING  = 0;
    localparam int STAT_RX_VALID = 1;
    localparam int STAT_TX_FULL  = 2;
    localparam int STAT_OVF      = 3;

    function automatic sel_e decode_sel(
        input logic [31:0] a,
        input logic [31:0] g,
        input logic [31:0] u,
        input logic [31:0] s
    );
        if (a == g) return SEL_GPIO;
        if (a == u) return SEL_UART;
        if (a == s) return SEL_STATUS;
        return SEL_NONE;
    endfunction

endpackage

// File: rtl/nanov_periph_ctrl_if.sv
// CPU-side serial-bus strobes and data between nanoV and the
// peripheral controller.
interface nanov_periph_ctrl_if;

    logic        is_addr;
    logic [31:0] addr_out;
    logic        is_data;
    logic [31:0] data_out;
    logic        is_data_in;
    logic [31:0] data_in;

    modport master (
        output is_addr, addr_out,
        output is_data, data_out,
        output is_data_in,
        input  data_in
    );

    modport slave (
        input  is_addr, addr_out,
        input  is_data, data_out,
        input  is_data_in,
        output data_in
    );

endinterface

// File: rtl/nanov_periph_ctrl_fifo.sv
// Synchronous FIFO with registered pointers and occupancy count;
// the head word is visible combinationally on o_dout.
module nanov_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4,
    localparam int AW = $clog2(DEPTH),
    localparam int CW = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    output logic [WIDTH-1:0] o_dout,
    output logic             o_full,
    output logic             o_empty,
    output logic [CW-1:0]    o_count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr;
    logic [AW-1:0]    r_rd;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign o_full  = (r_count == CW'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_dout  = r_mem[r_rd];

    // full is judged before the cycle, so a pop cannot make room
    assign w_push = i_push && !o_full;
    assign w_pop  = i_pop && !o_empty;

    always_ff @(posedge clk) begin
        if (w_push) r_mem[r_wr] <= i_din;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr    <= '0;
            r_rd    <= '0;
            r_count <= '0;
        end else begin
            if (w_push) r_wr <= r_wr + AW'(1);
            if (w_pop)  r_rd <= r_rd + AW'(1);
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/nanov_periph_ctrl.sv
// Address decode, GPIO/status registers, read mux and the TX
// scheduler that drains the byte FIFO into the UART transmitter.
module nanov_periph_ctrl
    import nanov_periph_pkg::*;
#(
    parameter int          TX_DEPTH         = 4,
    parameter logic [31:0] ADDR_GPIO        = DEF_ADDR_GPIO,
    parameter logic [31:0] ADDR_UART        = DEF_ADDR_UART,
    parameter logic [31:0] ADDR_UART_STATUS = DEF_ADDR_UART_STATUS
) (
    input  logic                      clk,
    input  logic                      rst,
    nanov_periph_ctrl_if.slave        bus,
    input  logic [2:0]                buttons,
    output logic [31:0]               led_data,
    input  logic                      uart_tx_busy,
    output logic                      uart_tx_en,
    output logic [7:0]                uart_tx_data,
    input  logic                      uart_rx_valid,
    input  logic [7:0]                uart_rx_data,
    output logic                      uart_rx_read
);

    localparam int CW = $clog2(TX_DEPTH) + 1;

    sel_e          r_sel;
    tx_st_e        r_state;
    tx_st_e        w_next;
    logic [31:0]   r_led;
    logic          r_ovf;
    logic          r_wait;
    logic          r_tx_en;
    logic [7:0]    r_tx_data;

    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [7:0]    w_head;
    logic          w_ovf_set;
    logic          w_ovf_clr;
    logic          w_pending;
    logic [7:0]    w_status;
    logic [31:0]   w_rdata;

    nanov_sync_fifo #(
        .WIDTH (8),
        .DEPTH (TX_DEPTH)
    ) u_tx_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (bus.data_out[7:0]),
        .i_pop   (w_pop),
        .o_dout  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    assign w_push    = bus.is_data && (r_sel == SEL_UART);
    assign w_ovf_set = w_push && w_full;
    assign w_ovf_clr = bus.is_data_in && (r_sel == SEL_STATUS);
    assign w_pending = (w_count != '0) || (r_state != ST_IDLE)
                     || uart_tx_busy;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sel <= SEL_NONE;
            r_led <= '0;
            r_ovf <= 1'b0;
        end else begin
            if (bus.is_addr)
                r_sel <= decode_sel(bus.addr_out, ADDR_GPIO,
                                    ADDR_UART, ADDR_UART_STATUS);
            if (bus.is_data && (r_sel == SEL_GPIO))
                r_led <= bus.data_out;
            r_ovf <= w_ovf_set || (r_ovf && !w_ovf_clr);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_wait    <= 1'b0;
            r_tx_en   <= 1'b0;
            r_tx_data <= '0;
        end else begin
            r_state <= w_next;
            r_wait  <= (r_state == ST_START) && !uart_tx_busy;
            r_tx_en <= w_pop;
            if (w_pop) r_tx_data <= w_head;
        end
    end

    // START gives busy two cycles to rise before assuming the byte went out
    always_comb begin
        w_next = r_state;
        w_pop  = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (!w_empty && !uart_tx_busy) begin
                    w_pop  = 1'b1;
                    w_next = ST_START;
                end
            end
            ST_START: begin
                if (uart_tx_busy)
                    w_next = ST_DRAIN;
                else if (r_wait)
                    w_next = ST_IDLE;
            end
            ST_DRAIN: begin
                if (!uart_tx_busy) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_status                = '0;
        w_status[STAT_PENDING]  = w_pending;
        w_status[STAT_RX_VALID] = uart_rx_valid;
        w_status[STAT_TX_FULL]  = w_full;
        w_status[STAT_OVF]      = r_ovf;
    end

    always_comb begin
        w_rdata = '0;
        unique case (r_sel)
            SEL_GPIO:   w_rdata = {29'b0, buttons};
            SEL_UART:   w_rdata = {24'b0, uart_rx_data};
            SEL_STATUS: w_rdata = {24'b0, w_status};
            default:    w_rdata = '0;
        endcase
    end

    assign bus.data_in   = w_rdata;
    assign led_data      = r_led;
    assign uart_tx_en    = r_tx_en;
    assign uart_tx_data  = r_tx_data;
    assign uart_rx_read  = (r_sel == SEL_UART) && bus.is_data_in;

endmodule

// File: tb/tb_nanov_periph_ctrl.sv
// Bench for nanov_periph_ctrl: bus tasks, a UART transmitter model
// and a scoreboard of bytes expected on uart_tx_data.
module tb_nanov_periph_ctrl;

    localparam logic [31:0] A_GPIO = 32'h1000_0000;
    localparam logic [31:0] A_UART = 32'h1000_0010;
    localparam logic [31:0] A_STAT = 32'h1000_0014;
    localparam logic [31:0] A_NONE = 32'h1000_0020;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [2:0]  buttons = '0;
    logic [31:0] led_data;
    logic        uart_tx_busy;
    logic        uart_tx_en;
    logic [7:0]  uart_tx_data;
    logic        uart_rx_valid = 1'b0;
    logic [7:0]  uart_rx_data = '0;
    logic        uart_rx_read;

    nanov_periph_ctrl_if bus ();

    nanov_periph_ctrl #(.TX_DEPTH(4)) dut (
        .clk           (clk),
        .rst           (rst),
        .bus           (bus),
        .buttons       (buttons),
        .led_data      (led_data),
        .uart_tx_busy  (uart_tx_busy),
        .uart_tx_en    (uart_tx_en),
        .uart_tx_data  (uart_tx_data),
        .uart_rx_valid (uart_rx_valid),
        .uart_rx_data  (uart_rx_data),
        .uart_rx_read  (uart_rx_read)
    );

    always #5 clk = ~clk;

    int         n_chk = 0;
    int         n_err = 0;
    logic [7:0] sb_q[$];
    int         tx_count = 0;
    int         busy_len = 4;
    bit         hold_busy = 1'b0;
    int         base;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // transmitter model: busy for busy_len cycles after each start pulse
    initial begin : uart_model
        int  cnt;
        bit  prev_en;
        cnt = 0;
        prev_en = 1'b0;
        uart_tx_busy = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                cnt = 0;
                uart_tx_busy = 1'b0;
                prev_en = 1'b0;
            end else begin
                if (uart_tx_en) begin
                    tx_count++;
                    chk("tx_en_1cyc", {31'b0, prev_en}, 32'd0);
                    if (sb_q.size() == 0)
                        chk("tx_unexpected", 32'd1, 32'd0);
                    else
                        chk("tx_data", {24'b0, uart_tx_data},
                            {24'b0, sb_q.pop_front()});
                    cnt = busy_len;
                end else if (cnt > 0) begin
                    cnt--;
                end
                uart_tx_busy = hold_busy || (cnt > 0);
                prev_en = uart_tx_en;
            end
        end
    end

    task automatic set_addr(input logic [31:0] a);
        bus.is_addr  = 1'b1;
        bus.addr_out = a;
        @(negedge clk);
        bus.is_addr  = 1'b0;
    endtask

    task automatic wr(input logic [31:0] d);
        bus.is_data  = 1'b1;
        bus.data_out = d;
        @(negedge clk);
        bus.is_data  = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [31:0] exp);
        bus.is_data_in = 1'b1;
        #1 chk(tag, bus.data_in, exp);
        @(negedge clk);
        bus.is_data_in = 1'b0;
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (sb_q.size() == 0 && !uart_tx_busy) begin
                ok = 1'b1;
                break;
            end
        end
        chk("drain_timeout", {31'b0, ok}, 32'd1);
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bus.is_addr    = 1'b0;
        bus.addr_out   = '0;
        bus.is_data    = 1'b0;
        bus.data_out   = '0;
        bus.is_data_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_led", led_data, 32'd0);
        chk("rst_tx_en", {31'b0, uart_tx_en}, 32'd0);
        chk("rst_tx_data", {24'b0, uart_tx_data}, 32'd0);
        chk("rst_data_in", bus.data_in, 32'd0);
        @(negedge clk);

        // GPIO write and button read
        set_addr(A_GPIO);
        wr(32'hA5A5_0F0F);
        chk("gpio_led", led_data, 32'hA5A5_0F0F);
        buttons = 3'b101;
        rd("gpio_buttons", 32'h5);

        // is_data alongside is_addr still targets the old select
        bus.is_addr  = 1'b1;
        bus.addr_out = A_NONE;
        bus.is_data  = 1'b1;
        bus.data_out = 32'h0000_1234;
        @(negedge clk);
        bus.is_addr  = 1'b0;
        bus.is_data  = 1'b0;
        chk("old_sel_led", led_data, 32'h0000_1234);
        rd("old_sel_none", 32'd0);

        // single byte: start pulse two cycles after the write
        set_addr(A_UART);
        base = tx_count;
        sb_q.push_back(8'h41);
        bus.is_data  = 1'b1;
        bus.data_out = 32'h0000_0041;
        @(negedge clk);
        bus.is_data  = 1'b0;
        #1 chk("lat_n1", {31'b0, uart_tx_en}, 32'd0);
        @(negedge clk);
        #1 chk("lat_n2", {31'b0, uart_tx_en}, 32'd1);
        chk("lat_data", {24'b0, uart_tx_data}, 32'h41);
        @(negedge clk);
        #1 chk("lat_n3", {31'b0, uart_tx_en}, 32'd0);
        set_addr(A_STAT);
        rd("stat_busy", 32'h1);
        wait_idle();
        chk("one_tx", tx_count, base + 1);
        rd("stat_idle", 32'h0);

        // overflow while the transmitter is held busy
        hold_busy = 1'b1;
        repeat (2) @(negedge clk);
        set_addr(A_UART);
        base = tx_count;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) sb_q.push_back(8'h30 + 8'(i));
            wr(32'h30 + i);
        end
        repeat (5) @(negedge clk);
        chk("held_no_tx", tx_count, base);
        set_addr(A_STAT);
        rd("stat_ovf", 32'hD);
        rd("stat_ovf_clr", 32'h5);
        hold_busy = 1'b0;
        wait_idle();
        chk("drain_cnt", tx_count, base + 4);
        rd("stat_drained", 32'h0);

        // unmapped address: writes ignored, reads zero
        set_addr(A_NONE);
        base = tx_count;
        wr(32'hFF);
        chk("none_led", led_data, 32'h0000_1234);
        rd("none_rd", 32'd0);
        repeat (5) @(negedge clk);
        chk("none_no_tx", tx_count, base);

        // UART receive read strobe
        set_addr(A_UART);
        uart_rx_valid  = 1'b1;
        uart_rx_data   = 8'h5A;
        bus.is_data_in = 1'b1;
        #1;
        chk("rx_read_hi", {31'b0, uart_rx_read}, 32'd1);
        chk("rx_data", bus.data_in, 32'h5A);
        @(negedge clk);
        bus.is_data_in = 1'b0;
        #1 chk("rx_read_lo", {31'b0, uart_rx_read}, 32'd0);
        uart_rx_valid = 1'b0;

        // reset in DRAIN with two bytes queued
        busy_len = 10;
        base = tx_count;
        sb_q.push_back(8'h61);
        wr(32'h61);
        wr(32'h62);
        wr(32'h63);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst2_tx_en", {31'b0, uart_tx_en}, 32'd0);
        chk("rst2_led", led_data, 32'd0);
        chk("rst2_sel", bus.data_in, 32'd0);
        repeat (20) @(negedge clk);
        chk("rst2_no_tx", tx_count, base + 1);
        set_addr(A_STAT);
        rd("rst2_stat", 32'h0);
        chk("sb_empty", sb_q.size(), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
